// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/branch/mult-div hazard detection, IF/ID and ID/EX control, mult/div busy sequencer
module pipeline_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             branch_d,
    input  logic             branch_taken_d,
    input  logic             jump_d,
    input  logic             md_use_d,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic [REG_W-1:0] write_reg_e,
    input  logic             mem_to_reg_m,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic             md_start_e,
    input  logic             md_div_e,
    output logic             stall_f,
    output logic             en_d,
    output logic             clr_d,
    output logic             clr_e,
    output logic             md_busy,
    output logic             md_done
);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic busy_i, done_i, hit_e, hit_m, lw_stall, br_stall, md_stall, stall_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE && md_start_e) begin
            state_nx = BUSY;
            cnt_nx   = md_div_e ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
        end else if (state == BUSY) begin
            state_nx = (cnt == '0) ? IDLE : BUSY;
            cnt_nx   = (cnt == '0) ? cnt : cnt - CW'(1);
        end
    end
    assign busy_i   = (state == BUSY);
    assign done_i   = busy_i && (cnt == '0);
    assign hit_e    = (write_reg_e != '0) && (write_reg_e == rs_d || write_reg_e == rt_d);
    assign hit_m    = (write_reg_m != '0) && (write_reg_m == rs_d || write_reg_m == rt_d);
    assign lw_stall = mem_to_reg_e && reg_write_e && hit_e;
    assign br_stall = branch_d && ((reg_write_e && hit_e) || (mem_to_reg_m && hit_m));
    assign md_stall = md_use_d && busy_i && !done_i;
    assign stall_i  = !rst && (lw_stall || br_stall || md_stall);
    assign stall_f  = stall_i;
    assign clr_e    = stall_i;
    assign clr_d    = !rst && (branch_taken_d || jump_d) && !stall_i;
    assign en_d     = !stall_i && !clr_d;
    assign md_busy  = !rst && busy_i;
    assign md_done  = !rst && done_i;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus checked against a cycle-count model
module tb_pipeline_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int MUL   = 4;
    localparam int DIV   = 32;
    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] rs_d, rt_d, write_reg_e, write_reg_m;
    logic branch_d, branch_taken_d, jump_d, md_use_d, reg_write_e, mem_to_reg_e;
    logic mem_to_reg_m, md_start_e, md_div_e;
    logic stall_f, en_d, clr_d, clr_e, md_busy, md_done;
    int total = 0;
    int bad = 0;
    int md_left = 0;
    pipeline_hazard_ctrl #(.REG_W(REG_W), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .branch_taken_d(branch_taken_d), .jump_d(jump_d), .md_use_d(md_use_d),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .write_reg_e(write_reg_e),
        .mem_to_reg_m(mem_to_reg_m), .write_reg_m(write_reg_m), .md_start_e(md_start_e),
        .md_div_e(md_div_e), .stall_f(stall_f), .en_d(en_d), .clr_d(clr_d), .clr_e(clr_e),
        .md_busy(md_busy), .md_done(md_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic clear();
        rst = 0; rs_d = 0; rt_d = 0; write_reg_e = 0; write_reg_m = 0;
        branch_d = 0; branch_taken_d = 0; jump_d = 0; md_use_d = 0;
        reg_write_e = 0; mem_to_reg_e = 0; mem_to_reg_m = 0; md_start_e = 0; md_div_e = 0;
    endtask
    // Inputs are set just after a falling edge; outputs are checked 1 time unit later,
    // then the model advances to match the following rising edge.
    task automatic step();
        logic e_busy, e_done, src_e, src_m, stall, flush;
        #1;
        e_busy = md_left > 0;
        e_done = md_left == 1;
        src_e = write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d);
        src_m = write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d);
        stall = (mem_to_reg_e && reg_write_e && src_e)
              || (branch_d && ((reg_write_e && src_e) || (mem_to_reg_m && src_m)))
              || (md_use_d && e_busy && !e_done);
        flush = (branch_taken_d || jump_d) && !stall;
        if (rst) begin
            stall = 0; flush = 0; e_busy = 0; e_done = 0;
        end
        chk("stall_f", stall_f, stall);
        chk("clr_e", clr_e, stall);
        chk("clr_d", clr_d, flush);
        chk("en_d", en_d, !stall && !flush);
        chk("md_busy", md_busy, e_busy);
        chk("md_done", md_done, e_done);
        if (rst) md_left = 0;
        else if (md_left > 0) md_left--;
        else if (md_start_e) md_left = md_div_e ? DIV : MUL;
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        clear();
        for (int i = 0; i < n; i++) step();
    endtask
    initial begin
        clear();
        rst = 1;
        @(negedge clk);
        step();
        step();
        idle(2);
        clear(); mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rt_d = 8; step();
        idle(1);
        clear(); mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 0; rt_d = 0; step();
        clear(); branch_taken_d = 1; branch_d = 1; rs_d = 3; rt_d = 4; step();
        clear(); branch_d = 1; branch_taken_d = 1; rs_d = 9; write_reg_m = 9; mem_to_reg_m = 1; step();
        idle(1);
        clear(); md_start_e = 1; md_div_e = 1; step();
        clear(); md_use_d = 1;
        for (int i = 0; i < DIV + 1; i++) step();
        idle(1);
        clear(); md_start_e = 1; step();
        idle(3);
        clear(); md_start_e = 1; step();
        clear(); md_start_e = 1; step();
        idle(MUL + 1);
        clear(); md_start_e = 1; md_div_e = 1; step();
        idle(9);
        clear(); rst = 1; md_use_d = 1; jump_d = 1; step();
        step();
        idle(3);
        clear(); jump_d = 1; mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rs_d = 5; step();
        clear(); jump_d = 1; rs_d = 5; step();
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            rs_d = REG_W'($urandom_range(0, 3));
            rt_d = REG_W'($urandom_range(0, 3));
            write_reg_e = REG_W'($urandom_range(0, 3));
            write_reg_m = REG_W'($urandom_range(0, 3));
            branch_d = $urandom_range(0, 1) == 1;
            branch_taken_d = $urandom_range(0, 3) == 0;
            jump_d = $urandom_range(0, 7) == 0;
            md_use_d = $urandom_range(0, 2) == 0;
            reg_write_e = $urandom_range(0, 1) == 1;
            mem_to_reg_e = $urandom_range(0, 1) == 1;
            mem_to_reg_m = $urandom_range(0, 1) == 1;
            md_start_e = $urandom_range(0, 5) == 0;
            md_div_e = $urandom_range(0, 3) == 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
